// File: rtl/rs_gf_pkg.sv
// GF(2^8) definitions shared by the Berlekamp-Massey engine: field constants,
// FSM state encoding and a table-driven multiplicative inverse.
package rs_gf_pkg;

  localparam int GF_W = 8;
  localparam logic [GF_W-1:0] GF_POLY = 8'h1D;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DISC,
    UPDATE,
    OUT
  } bm_state_t;

  // Builds the inverse table from alpha powers: inv(alpha^i) = alpha^(255-i).
  function automatic logic [GF_W*256-1:0] gf_inv_build();
    logic [GF_W*256-1:0] exp_t;
    logic [GF_W*256-1:0] tbl;
    logic [GF_W-1:0] e;
    logic [10:0] src;
    logic [10:0] dst;
    exp_t = '0;
    tbl = '0;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      dst = 11'(i * 8);
      exp_t[dst +: 8] = e;
      e = {e[6:0], 1'b0} ^ (e[7] ? GF_POLY : 8'h00);
    end
    for (int i = 0; i < 255; i++) begin
      src = 11'(i * 8);
      dst = {exp_t[src +: 8], 3'b000};
      src = 11'(((255 - i) % 255) * 8);
      tbl[dst +: 8] = exp_t[src +: 8];
    end
    return tbl;
  endfunction

  localparam logic [GF_W*256-1:0] GF_INV_TABLE = gf_inv_build();

  // inv(0) is defined as 0; b never reaches 0 inside the engine.
  function automatic logic [GF_W-1:0] gf_inv(input logic [GF_W-1:0] a);
    return GF_INV_TABLE[{a, 3'b000} +: GF_W];
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, shift-and-add reduced by the field polynomial.
module gf256_mul
  import rs_gf_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  output logic [GF_W-1:0] p
);

  logic [GF_W-1:0] acc;
  logic [GF_W-1:0] aa;

  always_comb begin
    acc = '0;
    aa  = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[GF_W-2:0], 1'b0} ^ (aa[GF_W-1] ? GF_POLY : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/rs_bm_engine.sv
// Berlekamp-Massey error-locator solver: loads 2t syndromes, alternates
// DISC/UPDATE once per syndrome, then streams Lambda0..Lambda_T_CAP.
module rs_bm_engine
  import rs_gf_pkg::*;
#(
  parameter int NSYM = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [GF_W-1:0] syn_in,
  input  logic            syn_valid,
  output logic            syn_ready,
  output logic [GF_W-1:0] lambda_out,
  output logic            lambda_valid,
  output logic            lambda_last,
  input  logic            lambda_ready,
  output logic [5:0]      deg_out,
  output logic            fail,
  output logic            busy,
  output bm_state_t       state_dbg
);

  localparam int T_CAP = NSYM / 2;
  localparam logic [5:0] LAST_R = 6'(NSYM - 1);
  localparam logic [5:0] LAST_K = 6'(T_CAP);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds data stable while valid is high and ready low.

  bm_state_t       state_q;
  bm_state_t       state_d;
  logic [GF_W-1:0] syn_q [NSYM];
  logic [GF_W-1:0] c_q   [T_CAP+1];
  logic [GF_W-1:0] bb_q  [T_CAP+1];
  logic [5:0]      l_q;
  logic [5:0]      m_q;
  logic [5:0]      r_q;
  logic [5:0]      cnt_q;
  logic [5:0]      idx_q;
  logic [GF_W-1:0] b_q;
  logic [GF_W-1:0] d_q;

  logic [GF_W-1:0] disc_term [T_CAP+1];
  logic [GF_W-1:0] corr      [T_CAP+1];
  logic [GF_W-1:0] c_next    [T_CAP+1];
  logic [GF_W-1:0] d_comb;
  logic [GF_W-1:0] b_inv;
  logic [GF_W-1:0] coef;
  logic [5:0]      hi_idx;
  logic            fail_comb;

  // Discrepancy terms C[i]*S[r-i]; terms with i>r contribute nothing.
  for (genvar i = 0; i <= T_CAP; i++) begin : g_disc
    logic [GF_W-1:0] s_sel;
    always_comb begin
      s_sel = '0;
      for (int j = 0; j < NSYM; j++) begin
        if (int'(r_q) - i == j) s_sel = syn_q[j];
      end
    end
    gf256_mul u_mul (.a(c_q[i]), .b(s_sel), .p(disc_term[i]));
  end

  always_comb begin
    d_comb = '0;
    for (int i = 0; i <= T_CAP; i++) d_comb = d_comb ^ disc_term[i];
  end

  assign b_inv = gf_inv(b_q);
  gf256_mul u_scale (.a(d_q), .b(b_inv), .p(coef));

  // Correction (d/b)*x^m*B; products landing above T_CAP are simply dropped.
  for (genvar i = 0; i <= T_CAP; i++) begin : g_corr
    logic [GF_W-1:0] b_sh;
    always_comb begin
      b_sh = '0;
      for (int j = 0; j <= T_CAP; j++) begin
        if (j + int'(m_q) == i) b_sh = bb_q[j];
      end
    end
    gf256_mul u_mul (.a(coef), .b(b_sh), .p(corr[i]));
    assign c_next[i] = c_q[i] ^ corr[i];
  end

  always_comb begin
    hi_idx = '0;
    for (int j = 0; j <= T_CAP; j++) begin
      if (c_q[j] != '0) hi_idx = 6'(j);
    end
    fail_comb = (l_q > LAST_K) || (hi_idx != l_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (syn_valid && cnt_q == LAST_R) state_d = DISC;
      DISC:    state_d = UPDATE;
      UPDATE:  state_d = (r_q < LAST_R) ? DISC : OUT;
      OUT:     if (lambda_ready && idx_q == LAST_K) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    syn_ready    = 1'b0;
    lambda_valid = 1'b0;
    lambda_last  = 1'b0;
    lambda_out   = '0;
    deg_out      = '0;
    fail         = 1'b0;
    busy         = (state_q != IDLE);
    if (state_q == LOAD) syn_ready = 1'b1;
    if (state_q == OUT) begin
      lambda_valid = 1'b1;
      lambda_last  = (idx_q == LAST_K);
      deg_out      = l_q;
      fail         = fail_comb;
      for (int j = 0; j <= T_CAP; j++) begin
        if (j == int'(idx_q)) lambda_out = c_q[j];
      end
    end
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j <= T_CAP; j++) begin
        c_q[j]  <= '0;
        bb_q[j] <= '0;
      end
      for (int j = 0; j < NSYM; j++) syn_q[j] <= '0;
      l_q   <= '0;
      m_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      b_q   <= '0;
      d_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int j = 0; j <= T_CAP; j++) begin
              c_q[j]  <= (j == 0) ? 8'h01 : 8'h00;
              bb_q[j] <= (j == 0) ? 8'h01 : 8'h00;
            end
            l_q   <= 6'd0;
            m_q   <= 6'd1;
            b_q   <= 8'h01;
            r_q   <= 6'd0;
            cnt_q <= 6'd0;
            idx_q <= 6'd0;
            d_q   <= 8'h00;
          end
        end
        LOAD: begin
          if (syn_valid) begin
            for (int j = 0; j < NSYM; j++) begin
              if (j == int'(cnt_q)) syn_q[j] <= syn_in;
            end
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DISC: d_q <= d_comb;
        UPDATE: begin
          if (d_q != '0) begin
            for (int j = 0; j <= T_CAP; j++) c_q[j] <= c_next[j];
            if ({l_q, 1'b0} <= {1'b0, r_q}) begin
              for (int j = 0; j <= T_CAP; j++) bb_q[j] <= c_q[j];
              l_q <= r_q + 6'd1 - l_q;
              b_q <= d_q;
              m_q <= 6'd1;
            end else begin
              m_q <= m_q + 6'd1;
            end
          end else begin
            m_q <= m_q + 6'd1;
          end
          r_q   <= r_q + 6'd1;
          idx_q <= 6'd0;
        end
        OUT: if (lambda_ready) idx_q <= idx_q + 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_bm_engine.sv
// Directed bench for rs_bm_engine (NSYM=4): hand-derived locators pushed to a
// queue, popped by a negedge monitor that also checks latency and stall hold.
module tb_rs_bm_engine;
  import rs_gf_pkg::*;

  localparam int NSYM = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] syn_in;
  logic       syn_valid;
  logic       syn_ready;
  logic [7:0] lambda_out;
  logic       lambda_valid;
  logic       lambda_last;
  logic       lambda_ready;
  logic [5:0] deg_out;
  logic       fail;
  logic       busy;
  bm_state_t  state_dbg;

  rs_bm_engine #(.NSYM(NSYM)) dut (
    .clk(clk), .reset(reset), .start(start),
    .syn_in(syn_in), .syn_valid(syn_valid), .syn_ready(syn_ready),
    .lambda_out(lambda_out), .lambda_valid(lambda_valid),
    .lambda_last(lambda_last), .lambda_ready(lambda_ready),
    .deg_out(deg_out), .fail(fail), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic stall_mode = 1'b0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready pattern: always high, or low for 3 cycles ahead of every accepted beat.
  always @(posedge clk) begin
    #1;
    if (!stall_mode) lambda_ready = 1'b1;
    else if (lambda_valid) begin
      if (stall_cnt < 3) begin
        lambda_ready = 1'b0;
        stall_cnt++;
      end else begin
        lambda_ready = 1'b1;
        stall_cnt = 0;
      end
    end else begin
      lambda_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor
  int hs_cyc = 0;
  bit wait_first = 0;
  bit stalled = 0;
  logic [15:0] held;
  always @(negedge clk) begin
    logic [15:0] act;
    logic [15:0] e;
    act = {lambda_out, lambda_last, deg_out, fail};
    if (reset) begin
      wait_first = 0;
      stalled = 0;
    end else begin
      if (syn_valid && syn_ready) begin
        hs_cyc = cyc;
        wait_first = 1;
      end
      if (lambda_valid) begin
        if (wait_first) begin
          chk("latency", 32'(cyc - hs_cyc), 32'(2 * NSYM + 1));
          wait_first = 0;
        end
        if (stalled) chk("hold", 32'(act), 32'(held));
        if (lambda_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none", act);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 32'(act), 32'(e));
          end
          stalled = 0;
        end else begin
          stalled = 1;
          held = act;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic push_exp(input logic [23:0] lam, input logic [5:0] deg, input logic fl);
    exp_q.push_back({lam[23:16], 1'b0, deg, fl});
    exp_q.push_back({lam[15:8], 1'b0, deg, fl});
    exp_q.push_back({lam[7:0], 1'b1, deg, fl});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_syn(input logic [31:0] syn, input int start_at);
    int n;
    for (int k = 0; k < NSYM; k++) begin
      syn_in = syn[31 - 8 * k -: 8];
      syn_valid = 1'b1;
      start = (k == start_at);
      n = 0;
      while (!syn_ready && n < 20) begin
        tick();
        n++;
      end
      if (!syn_ready) begin
        checks++;
        failures++;
        $display("FAIL syn_ready_timeout actual=0 required=1");
      end
      tick();
      start = 1'b0;
    end
    syn_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d_beats_left required=0", name, exp_q.size());
      exp_q.delete();
    end
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic decode(input string name, input logic [31:0] syn, input logic [23:0] lam,
                        input logic [5:0] deg, input logic fl, input bit start_load,
                        input bit start_out);
    int n;
    push_exp(lam, deg, fl);
    pulse_start();
    send_syn(syn, start_load ? 1 : -1);
    if (start_out) begin
      n = 0;
      while (!lambda_valid && n < 50) begin
        tick();
        n++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    syn_in = 8'h00;
    syn_valid = 1'b0;
    lambda_ready = 1'b1;
    tick();
    tick();
    chk("rst_syn_ready", 32'(syn_ready), 32'd0);
    chk("rst_lambda_valid", 32'(lambda_valid), 32'd0);
    chk("rst_lambda_last", 32'(lambda_last), 32'd0);
    chk("rst_lambda_out", 32'(lambda_out), 32'd0);
    chk("rst_deg_out", 32'(deg_out), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    decode("single_x2", 32'h01020408, 24'h010200, 6'd1, 1'b0, 0, 0);
    decode("all_zero", 32'h00000000, 24'h010000, 6'd0, 1'b0, 0, 0);
    decode("uncorrectable", 32'h01000000, 24'h010000, 6'd1, 1'b1, 0, 0);
    decode("single_x8", 32'h0108403A, 24'h010800, 6'd1, 1'b0, 0, 0);
    decode("two_errors", 32'h00030509, 24'h010302, 6'd2, 1'b0, 0, 0);

    stall_mode = 1'b1;
    decode("stalled", 32'h01020408, 24'h010200, 6'd1, 1'b0, 0, 0);
    stall_mode = 1'b0;
    tick();

    // Abort in the first DISC cycle, right after the last syndrome.
    pulse_start();
    send_syn(32'h01020408, -1);
    chk("abort_in_disc", 32'(state_dbg), 32'(DISC));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(lambda_valid), 32'd0);
    decode("after_abort", 32'h01020408, 24'h010200, 6'd1, 1'b0, 0, 0);

    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("reset_over_start_busy", 32'(busy), 32'd0);

    decode("start_ignored", 32'h01020408, 24'h010200, 6'd1, 1'b0, 1, 1);
    tick();
    chk("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_bm_engine.md
RS_BM_ENGINE -- requirements
Module: rs_bm_engine

Interface
REQ-001 SHALL have parameter NSYM, default 16, meaning the number of syndromes (2t); legal values are even numbers 2..32.
REQ-002 SHALL have parameter T_CAP = NSYM/2 (derived, not overridable), meaning the correction capability.
REQ-003 SHALL use one clock and a synchronous, active-high reset; the port list below starts with them.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a decode; sampled only in IDLE.
REQ-007 syn_in  in  8  syndrome value, S0 first.
REQ-008 syn_valid  in  1  syn_in is valid.
REQ-009 syn_ready  out  1  engine accepts a syndrome this cycle.
REQ-010 lambda_out  out  8  locator coefficient, Lambda0 first.
REQ-011 lambda_valid  out  1  lambda_out is valid.
REQ-012 lambda_last  out  1  marks coefficient Lambda_T_CAP.
REQ-013 lambda_ready  in  1  downstream accepts the coefficient.
REQ-014 deg_out  out  6  final L; stable while lambda_valid=1.
REQ-015 fail  out  1  uncorrectable flag; stable while lambda_valid=1.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DISC, UPDATE and OUT.
REQ-018 FSM transitions SHALL be: IDLE->LOAD on start; LOAD->DISC after NSYM handshakes; DISC->UPDATE always; UPDATE->DISC while r<NSYM-1, else ->OUT; OUT->IDLE on the lambda_last handshake.
REQ-019 syn_ready SHALL be 1 only in LOAD; a syndrome is stored when syn_valid and syn_ready are both high; syn_valid outside LOAD is ignored.
REQ-020 On entry to LOAD the engine SHALL initialise C=1, B=1, L=0, m=1, b=1 and r=0, and clear all higher C and B coefficients.
REQ-021 DISC (1 cycle) SHALL register the discrepancy d = XOR over i=0..r of C[i]*S[r-i], using GF(2^8) multiplication with primitive polynomial 0x11D.
REQ-022 UPDATE (1 cycle) SHALL apply the following rules, then increment r:
- d=0: m <= m+1.
- d!=0 and 2L<=r: C <= C + (d*b^-1)*x^m*B, B <= old C, L <= r+1-L, b <= d, m <= 1.
- d!=0 and 2L>r: C updated as above, m <= m+1.
REQ-023 Coefficient index arithmetic SHALL discard terms above index T_CAP without error.
REQ-024 Latency SHALL be exactly 2*NSYM+1 cycles from the last syndrome handshake to the first cycle of lambda_valid.
REQ-025 OUT SHALL present T_CAP+1 coefficients, Lambda0..Lambda_T_CAP, advancing one per lambda_valid&lambda_ready handshake.
REQ-026 While lambda_ready=0, lambda_out and lambda_last SHALL hold stable.
REQ-027 fail SHALL be 1 when L>T_CAP or when the highest nonzero index of C differs from L.
REQ-028 start SHALL be ignored when busy=1.
REQ-029 All-zero syndromes SHALL give Lambda=1, deg_out=0 and fail=0.

Reset
REQ-030 reset SHALL force the IDLE state and the following output values: syn_ready=0, lambda_valid=0, lambda_last=0, lambda_out=0, deg_out=0, fail=0, busy=0.
REQ-031 A reset asserted mid-decode SHALL abort the decode; the next start SHALL then decode cleanly.
REQ-032 If reset and start are high in the same cycle, reset SHALL take priority.

Structure
REQ-033 Package rs_gf_pkg SHALL hold GF_W=8, GF_POLY=8'h1D, the FSM state typedef, and a gf_inv function implemented as a 256-entry table.
REQ-034 The engine SHALL instantiate T_CAP+1 copies of sub-module gf256_mul (combinational) for the discrepancy and the same number for the correction term.

Verification
REQ-035 NSYM=4, S=01,02,04,08 -> outputs 01,02,00, deg_out=1, fail=0.
REQ-036 NSYM=4, S=00,00,00,00 -> outputs 01,00,00, deg_out=0, fail=0.
REQ-037 NSYM=4, S=01,00,00,00 -> outputs 01,00,00, deg_out=1, fail=1.
REQ-038 Case of REQ-035 with lambda_ready held low 3 cycles per beat -> identical data with values held stable, and the first lambda_valid exactly 9 cycles after the last syndrome handshake.
REQ-039 Reset pulse during DISC, then the REQ-035 stimulus -> busy=0 the cycle after reset, then the REQ-035 result.
REQ-040 start pulsed during LOAD and during OUT -> ignored, and the decode result is unchanged.
